// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave register file.
//   i2c_state_e : byte-level protocol FSM states
//   I2C_ACK / I2C_NACK : SDA level of the ninth bit
//   RW_READ : value of the R/W bit that selects a read transfer
//   maj3 : 2-of-3 majority vote used by the optional glitch filter
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    IDX,
    IDX_ACK,
    WR,
    WR_ACK,
    RD,
    MACK
  } i2c_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic RW_READ  = 1'b1;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the SCL/SDA pads into the clk domain and produces bus events.
// Optional feature macro: I2C_SLAVE_GLITCH_FILT_EN (3-sample majority filter).
// Ports:
//   clk, rst_n         : system clock, async active-low reset
//   scl_i, sda_i       : raw pad inputs
//   sda                : conditioned SDA level, aligned with the event pulses
//   scl_rise, scl_fall : one-clk SCL edge pulses
//   start, stop        : one-clk START / STOP condition pulses
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync, sda_sync;
  logic       scl_f, sda_f;
  logic       scl_d, sda_d;

  // Two-flop synchroniser; idle bus is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILT_EN
  logic [2:0] scl_hist, sda_hist;

  // A single-clk pulse never holds two of the three history slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_hist <= 3'b111;
      sda_hist <= 3'b111;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[1:0], scl_sync[1]};
      sda_hist <= {sda_hist[1:0], sda_sync[1]};
      scl_f    <= maj3(scl_hist);
      sda_f    <= maj3(sda_hist);
    end
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  // Edge and condition detection; SCL must be stable high for START/STOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      sda      <= 1'b1;
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start    <= 1'b0;
      stop     <= 1'b0;
    end else begin
      scl_d    <= scl_f;
      sda_d    <= sda_f;
      sda      <= sda_f;
      scl_rise <= scl_f & ~scl_d;
      scl_fall <= ~scl_f & scl_d;
      start    <= scl_f & scl_d & sda_d & ~sda_f;
      stop     <= scl_f & scl_d & ~sda_d & sda_f;
    end
  end

endmodule

// File: rtl/i2c_slave_regfile.sv
// I2C slave serving NUM_REGS x 8-bit registers with an auto-incrementing index.
// Optional feature macro: I2C_SLAVE_GLITCH_FILT_EN (SCL/SDA glitch filter in i2c_bus_sync).
// Ports:
//   clk, RST_N    : system clock (>= 16x SCL), async active-low reset
//   SCL_I, SDA_I  : pad inputs
//   SDA_OE        : 1 pulls SDA low (open-drain)
//   regs_q        : flat register contents, reg k at [8k+7:8k]
//   wr_stb        : one-clk pulse per register written over I2C
//   wr_idx/wr_data: index and data of that write, valid with wr_stb
//   busy          : transfer addressed to this slave in progress
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = 7'h55,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned IDX_W     = $clog2(NUM_REGS),
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic                  clk,
  input  logic                  RST_N,
  input  logic                  SCL_I,
  input  logic                  SDA_I,
  output logic                  SDA_OE,
  output logic [NUM_REGS*8-1:0] regs_q,
  output logic                  wr_stb,
  output logic [IDX_W-1:0]      wr_idx,
  output logic [7:0]            wr_data,
  output logic                  busy
);

  logic sda_s, scl_rise, scl_fall, start, stop;

  i2c_bus_sync u_bus_sync (
    .clk      (clk),
    .rst_n    (RST_N),
    .scl_i    (SCL_I),
    .sda_i    (SDA_I),
    .sda      (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  i2c_state_e       state_q, state_nx;
  logic [3:0]       bit_cnt_q, bit_cnt_nx;
  logic [7:0]       shift_q, shift_nx;
  logic [IDX_W-1:0] idx_q, idx_nx, idx_inc_c;
  logic             sda_oe_nx, busy_nx, wr_en_c;
  logic [7:0]       rd_byte_c;
  logic [7:0]       regs [NUM_REGS];

  assign rd_byte_c = regs[idx_q];
  assign idx_inc_c = (32'(idx_q) == NUM_REGS - 32'd1) ? '0 : idx_q + IDX_W'(1);

  for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_flat
    assign regs_q[8*k +: 8] = regs[k];
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      idx_q     <= '0;
      SDA_OE    <= 1'b0;
      busy      <= 1'b0;
      wr_stb    <= 1'b0;
      wr_idx    <= '0;
      wr_data   <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= RESET_VAL;
    end else begin
      state_q   <= state_nx;
      bit_cnt_q <= bit_cnt_nx;
      shift_q   <= shift_nx;
      idx_q     <= idx_nx;
      SDA_OE    <= sda_oe_nx;
      busy      <= busy_nx;
      wr_stb    <= wr_en_c;
      if (wr_en_c) begin
        regs[idx_q] <= shift_q;
        wr_idx      <= idx_q;
        wr_data     <= shift_q;
      end
    end
  end

  // Protocol FSM: bits shift in on SCL rise, SDA_OE only moves on SCL fall.
  always_comb begin
    state_nx   = state_q;
    bit_cnt_nx = bit_cnt_q;
    shift_nx   = shift_q;
    idx_nx     = idx_q;
    sda_oe_nx  = SDA_OE;
    busy_nx    = busy;
    wr_en_c    = 1'b0;

    if (stop) begin
      state_nx  = IDLE;
      sda_oe_nx = 1'b0;
      busy_nx   = 1'b0;
    end else if (start) begin
      state_nx   = ADDR;
      bit_cnt_nx = '0;
      sda_oe_nx  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR, IDX, WR: begin
          if (scl_rise) begin
            shift_nx   = {shift_q[6:0], sda_s};
            bit_cnt_nx = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (state_q == ADDR) begin
              if (shift_q[7:1] == DEV_ADDR) begin
                state_nx  = ADDR_ACK;
                sda_oe_nx = 1'b1;
                busy_nx   = 1'b1;
              end else begin
                state_nx  = IDLE;
                sda_oe_nx = 1'b0;
                busy_nx   = 1'b0;
              end
            end else if (state_q == IDX) begin
              if (32'(shift_q) < NUM_REGS) begin
                state_nx  = IDX_ACK;
                idx_nx    = IDX_W'(shift_q);
                sda_oe_nx = 1'b1;
              end else begin
                state_nx  = IDLE;
                sda_oe_nx = 1'b0;
                busy_nx   = 1'b0;
              end
            end else begin
              state_nx  = WR_ACK;
              sda_oe_nx = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_nx = '0;
            if (shift_q[0] == RW_READ) begin
              // First read bit goes out on the same fall that ends the ACK.
              state_nx  = RD;
              shift_nx  = rd_byte_c;
              sda_oe_nx = ~rd_byte_c[7];
            end else begin
              state_nx  = IDX;
              sda_oe_nx = 1'b0;
            end
          end
        end
        IDX_ACK: begin
          if (scl_fall) begin
            state_nx   = WR;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
          end
        end
        WR_ACK: begin
          // Commit only once the ACK clock completes; a STOP inside it aborts.
          if (scl_fall) begin
            state_nx   = WR;
            bit_cnt_nx = '0;
            sda_oe_nx  = 1'b0;
            wr_en_c    = 1'b1;
            idx_nx     = idx_inc_c;
          end
        end
        RD: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              state_nx  = MACK;
              sda_oe_nx = 1'b0;
              idx_nx    = idx_inc_c;
            end else begin
              shift_nx  = {shift_q[6:0], 1'b0};
              sda_oe_nx = ~shift_q[6];
            end
          end
        end
        MACK: begin
          if (scl_rise) begin
            shift_nx = {shift_q[7:1], sda_s};
          end else if (scl_fall) begin
            if (shift_q[0] == I2C_ACK) begin
              state_nx   = RD;
              bit_cnt_nx = '0;
              shift_nx   = rd_byte_c;
              sda_oe_nx  = ~rd_byte_c[7];
            end else begin
              state_nx  = IDLE;
              sda_oe_nx = 1'b0;
              busy_nx   = 1'b0;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master on a wired-AND SDA.
module tb_i2c_slave_regfile;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned IDX_W    = 4;
  localparam int          PH       = 20;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  scl, sda_m;
  logic                  sda_oe, wr_stb, busy;
  logic [NUM_REGS*8-1:0] regs_q;
  logic [IDX_W-1:0]      wr_idx;
  logic [7:0]            wr_data;
  wire                   sda_bus = sda_m & ~sda_oe;

  int               n_tests = 0;
  int               n_fail  = 0;
  int               wr_cnt  = 0;
  logic [IDX_W-1:0] last_idx;
  logic [7:0]       last_data;
  logic             oe_seen = 1'b0;
  logic             ack;
  logic [7:0]       rb;

  always #5 clk = ~clk;

  i2c_slave_regfile #(
    .DEV_ADDR (7'h55),
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .RESET_VAL(8'h00)
  ) u_dut (
    .clk    (clk),
    .RST_N  (rst_n),
    .SCL_I  (scl),
    .SDA_I  (sda_bus),
    .SDA_OE (sda_oe),
    .regs_q (regs_q),
    .wr_stb (wr_stb),
    .wr_idx (wr_idx),
    .wr_data(wr_data),
    .busy   (busy)
  );

  always @(negedge clk) begin
    if (wr_stb) begin
      wr_cnt    = wr_cnt + 1;
      last_idx  = wr_idx;
      last_data = wr_data;
    end
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // START from idle, or repeated START with SCL low.
  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    sda_m = 1'b0; wait_clks(PH);
    scl   = 1'b0; wait_clks(PH);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    sda_m = 1'b1; wait_clks(PH);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    scl   = 1'b0; wait_clks(PH);
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    a     = sda_bus;
    scl   = 1'b0; wait_clks(PH);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wait_clks(PH);
      scl  = 1'b1; wait_clks(PH);
      b[i] = sda_bus;
      scl  = 1'b0;
    end
    wait_clks(PH);
    sda_m = mack; wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    scl   = 1'b0; wait_clks(PH);
    sda_m = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; scl = 1'b1; sda_m = 1'b1;
    wait_clks(5);
    check_eq("rst_sda_oe", 32'(sda_oe), 32'h0);
    check_eq("rst_busy",   32'(busy),   32'h0);
    check_eq("rst_wr_stb", 32'(wr_stb), 32'h0);
    check_eq("rst_wr_idx", 32'(wr_idx), 32'h0);
    check_eq("rst_regs",   32'(regs_q == '0), 32'h1);
    rst_n = 1'b1;
    wait_clks(5);

    // 1: single write to reg 3
    i2c_start();
    wr_byte(8'hAA, ack); check_eq("t1_ack_addr", 32'(ack), 32'h0);
    wr_byte(8'h03, ack); check_eq("t1_ack_idx",  32'(ack), 32'h0);
    wr_byte(8'h57, ack); check_eq("t1_ack_data", 32'(ack), 32'h0);
    i2c_stop();
    check_eq("t1_wr_cnt",  32'(wr_cnt),    32'd1);
    check_eq("t1_wr_idx",  32'(last_idx),  32'd3);
    check_eq("t1_wr_data", 32'(last_data), 32'h57);
    check_eq("t1_reg3",    32'(regs_q[31:24]), 32'h57);

    // 2: index wrap 15 -> 0, busy until STOP
    i2c_start();
    wr_byte(8'hAA, ack);
    wr_byte(8'h0F, ack);
    wr_byte(8'h11, ack);
    wr_byte(8'h22, ack); check_eq("t2_ack_wrap", 32'(ack), 32'h0);
    check_eq("t2_busy_before_stop", 32'(busy), 32'h1);
    i2c_stop();
    check_eq("t2_busy_after_stop", 32'(busy), 32'h0);
    check_eq("t2_reg15", 32'(regs_q[8*15 +: 8]), 32'h11);
    check_eq("t2_reg0",  32'(regs_q[7:0]),       32'h22);
    check_eq("t2_wr_cnt", 32'(wr_cnt), 32'd3);

    // reg4 = C3, reg5 = 3C
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h04, ack);
    wr_byte(8'hC3, ack); wr_byte(8'h3C, ack);
    i2c_stop();
    check_eq("pre3_wr_cnt", 32'(wr_cnt), 32'd5);

    // 3: pointer write, repeated START, read two bytes
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h03, ack);
    i2c_start();
    wr_byte(8'hAB, ack); check_eq("t3_ack_rd_addr", 32'(ack), 32'h0);
    rd_byte(1'b0, rb);   check_eq("t3_rd0", 32'(rb), 32'h57);
    rd_byte(1'b1, rb);   check_eq("t3_rd1", 32'(rb), 32'hC3);
    check_eq("t3_sda_released", 32'(sda_oe), 32'h0);
    check_eq("t3_busy_after_nack", 32'(busy), 32'h0);
    i2c_stop();

    // 3b: pointer kept across STOP, read wraps 15 -> 0
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h0E, ack);
    i2c_stop();
    i2c_start();
    wr_byte(8'hAB, ack);
    rd_byte(1'b0, rb); check_eq("t3b_rd14", 32'(rb), 32'h00);
    rd_byte(1'b0, rb); check_eq("t3b_rd15", 32'(rb), 32'h11);
    rd_byte(1'b1, rb); check_eq("t3b_rd0",  32'(rb), 32'h22);
    i2c_stop();

    // 4: wrong address is ignored for the whole transfer
    oe_seen = 1'b0;
    i2c_start();
    wr_byte(8'hA8, ack); check_eq("t4_nack_addr", 32'(ack), 32'h1);
    check_eq("t4_busy", 32'(busy), 32'h0);
    wr_byte(8'h12, ack); check_eq("t4_nack_data", 32'(ack), 32'h1);
    i2c_stop();
    check_eq("t4_oe_seen", 32'(oe_seen), 32'h0);
    check_eq("t4_wr_cnt",  32'(wr_cnt),  32'd5);

    // 5a: out-of-range index NACKed, pointer unchanged
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h05, ack);
    i2c_stop();
    i2c_start();
    wr_byte(8'hAA, ack);
    wr_byte(8'h20, ack); check_eq("t5_nack_idx", 32'(ack), 32'h1);
    check_eq("t5_busy_after_nack", 32'(busy), 32'h0);
    i2c_stop();
    i2c_start();
    wr_byte(8'hAB, ack);
    rd_byte(1'b1, rb); check_eq("t5_idx_kept", 32'(rb), 32'h3C);
    i2c_stop();

    // 5b: START in the middle of a data byte aborts it
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h02, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    wr_byte(8'hAA, ack); check_eq("t5_ack_after_abort", 32'(ack), 32'h0);
    i2c_stop();
    check_eq("t5_wr_cnt", 32'(wr_cnt), 32'd5);
    check_eq("t5_reg2",   32'(regs_q[23:16]), 32'h00);

    // 6: one-clk SDA low glitch while SCL is high
    i2c_start();
    wr_byte(8'hAA, ack); wr_byte(8'h05, ack);
    sda_m = 1'b1; wait_clks(PH);
    scl   = 1'b1; wait_clks(PH);
    check_eq("t6_busy_pre", 32'(busy), 32'h1);
    sda_m = 1'b0; wait_clks(1);
    sda_m = 1'b1; wait_clks(PH);
`ifdef I2C_SLAVE_GLITCH_FILT_EN
    check_eq("t6_busy_glitch", 32'(busy), 32'h1);
`else
    check_eq("t6_busy_glitch", 32'(busy), 32'h0);
`endif
    scl = 1'b0; wait_clks(PH);
    i2c_stop();
    check_eq("t6_wr_cnt", 32'(wr_cnt), 32'd5);
    check_eq("t6_sda_oe", 32'(sda_oe), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
